// File: rtl/effective_address_unit_pkg.sv
// Shared word type, read-type code, FSM state encoding and auto-index window for the EA stage.
package memory_utils;

    typedef logic [11:0] word_t;

    localparam logic  DATA_READ     = 1'b0;
    localparam word_t AI_LO_DEFAULT = 12'o0010;
    localparam word_t AI_HI_DEFAULT = 12'o0017;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE,
        ERR
    } ea_state_t;

    function automatic logic in_window(input word_t addr, input word_t lo, input word_t hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/effective_address_unit_mem_request_port.sv
// Registered request port towards memory_controller: enables, address, write data and the
// per-access timeout counter. Completion or timeout drops the active enable on the same edge.
module mem_request_port
    import memory_utils::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  issue_rd,
    input  logic  issue_wr,
    input  word_t addr,
    input  word_t wdata,
    input  logic  mem_finished,
    output logic  mem_read_enable,
    output logic  mem_write_enable,
    output word_t mem_address,
    output word_t mem_write_data,
    output logic  req_rd,
    output logic  req_wr,
    output logic  done,
    output logic  timeout
);

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    logic [15:0] wait_count;
    logic        active;

    assign active = mem_read_enable || mem_write_enable;
    assign req_rd = mem_read_enable;
    assign req_wr = mem_write_enable;
    assign done   = active && mem_finished;

    always_comb begin
        timeout = 1'b0;
        if (MEM_TIMEOUT != 0)
            timeout = active && !mem_finished && (wait_count == WAIT_LAST);
    end

    // A write issued on the read's completion edge replaces the read enable in one step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            wait_count       <= '0;
        end else if (issue_rd) begin
            mem_read_enable  <= 1'b1;
            mem_write_enable <= 1'b0;
            mem_address      <= addr;
            wait_count       <= '0;
        end else if (issue_wr) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b1;
            mem_write_data   <= wdata;
            wait_count       <= '0;
        end else if (done || timeout) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
        end else if (active) begin
            wait_count <= wait_count + 16'd1;
        end
    end

endmodule

// File: rtl/effective_address_unit.sv
// PDP-8 memory-reference effective-address stage: page/direct address, indirection and auto-index.
// Optional EAU_STATS_EN adds saturating indirect/auto-index resolution counters.
module effective_address_unit
    import memory_utils::*;
#(
    parameter word_t       AI_LO       = AI_LO_DEFAULT,
    parameter word_t       AI_HI       = AI_HI_DEFAULT,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] ir,
    input  logic [11:0] pc,
    output logic        busy,
    output logic [11:0] ea,
    output logic        ea_valid,
    output logic        autoindexed,
    output logic        mem_error,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic        mem_read_type,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    input  logic [11:0] mem_read_data,
    input  logic        mem_finished
`ifdef EAU_STATS_EN
    ,
    output logic [15:0] indirect_count,
    output logic [15:0] autoindex_count
`endif
);

    ea_state_t state, state_next;
    word_t     direct;
    logic      accept;
    logic      issue_rd, issue_wr;
    logic      req_rd, req_wr, acc_done, acc_timeout;
    logic      ai_hit;
    logic      ld_direct, ld_read, ld_write;
    logic      unused_bits;

    assign direct        = ir[7] ? {pc[11:7], ir[6:0]} : {5'b0, ir[6:0]};
    assign accept        = (state == IDLE) && start;
    assign ai_hit        = in_window(mem_address, AI_LO, AI_HI);
    assign mem_read_type = DATA_READ;
    assign unused_bits   = ^{ir[11:9], pc[6:0]};

    mem_request_port #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_port (
        .clk             (clk),
        .reset           (reset),
        .issue_rd        (issue_rd),
        .issue_wr        (issue_wr),
        .addr            (direct),
        .wdata           (mem_read_data + 12'd1),
        .mem_finished    (mem_finished),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .req_rd          (req_rd),
        .req_wr          (req_wr),
        .done            (acc_done),
        .timeout         (acc_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = ir[8] ? RD : DONE;
            RD: begin
                if (acc_timeout)             state_next = ERR;
                else if (acc_done && req_rd) state_next = ai_hit ? WR : DONE;
            end
            WR: begin
                if (acc_timeout)             state_next = ERR;
                else if (acc_done && req_wr) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue_rd  = accept && ir[8];
        ld_direct = accept && !ir[8];
        issue_wr  = (state == RD) && acc_done && req_rd && ai_hit;
        ld_read   = (state == RD) && acc_done && req_rd && !ai_hit;
        ld_write  = (state == WR) && acc_done && req_wr;
    end

    // Result strobes are registered, so ea_valid/mem_error appear one cycle after DONE/ERR.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            ea          <= '0;
            ea_valid    <= 1'b0;
            autoindexed <= 1'b0;
            mem_error   <= 1'b0;
        end else begin
            ea_valid  <= (state == DONE);
            mem_error <= (state == ERR);
            if (accept)                                  busy <= 1'b1;
            else if ((state == DONE) || (state == ERR))  busy <= 1'b0;
            if (ld_direct)     ea <= direct;
            else if (ld_read)  ea <= mem_read_data;
            else if (ld_write) ea <= mem_write_data;
            if (accept)        autoindexed <= 1'b0;
            else if (ld_write) autoindexed <= 1'b1;
        end
    end

`ifdef EAU_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            indirect_count  <= '0;
            autoindex_count <= '0;
        end else begin
            if ((ld_read || ld_write) && (indirect_count != 16'hFFFF))
                indirect_count <= indirect_count + 16'd1;
            if (ld_write && (autoindex_count != 16'hFFFF))
                autoindex_count <= autoindex_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_effective_address_unit.sv
// Scoreboard bench for effective_address_unit with a latency-2 memory controller model.
module tb_effective_address_unit;

    typedef struct {
        logic        err;
        logic [11:0] ea;
        logic        ai;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] ir, pc;
    logic        busy, ea_valid, autoindexed, mem_error;
    logic [11:0] ea;
    logic        mem_read_enable, mem_write_enable, mem_read_type;
    logic [11:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_finished;
`ifdef EAU_STATS_EN
    logic [15:0] indirect_count, autoindex_count;
`endif

    effective_address_unit dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .ir              (ir),
        .pc              (pc),
        .busy            (busy),
        .ea              (ea),
        .ea_valid        (ea_valid),
        .autoindexed     (autoindexed),
        .mem_error       (mem_error),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_read_type   (mem_read_type),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .mem_finished    (mem_finished)
`ifdef EAU_STATS_EN
        ,
        .indirect_count  (indirect_count),
        .autoindex_count (autoindex_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    exp_t exp_q[$];

    logic [11:0] mem [4096];
    logic        mem_auto = 1'b0;
    int          stale_req = 0;
    int          stale_served = 0;
    int          n_reads = 0, n_writes = 0;
    logic [11:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
    int          last_fin_cyc = 0;
    int          last_valid_cyc = 0;
    int          rd_cycles = 0, wr_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0o expected %0o (time %0t)", tag, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Controller model: completes each access two cycles after its enable is seen.
    initial begin : responder
        int lat;
        lat = 0;
        mem_finished  = 1'b0;
        mem_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_finished = 1'b0;
            if (stale_served != stale_req) begin
                stale_served  = stale_req;
                mem_read_data = 12'o1234;
                mem_finished  = 1'b1;
            end else if (mem_auto && (mem_read_enable || mem_write_enable)) begin
                if (lat == 2) begin
                    lat          = 0;
                    mem_finished = 1'b1;
                    last_fin_cyc = cyc;
                    if (mem_read_enable) begin
                        mem_read_data = mem[mem_address];
                        last_rd_addr  = mem_address;
                        n_reads++;
                    end else begin
                        last_wr_addr = mem_address;
                        last_wr_data = mem_write_data;
                        n_writes++;
                    end
                end else begin
                    lat++;
                end
            end else begin
                lat = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (mem_read_enable)  rd_cycles++;
            if (mem_write_enable) wr_cycles++;
            if (mem_read_enable && mem_write_enable) check("both_enables", 1, 0);
            if (ea_valid || mem_error) begin
                if (ea_valid) last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_is_error", {31'b0, mem_error}, {31'b0, e.err});
                    if (!e.err) begin
                        check("ea", {20'b0, ea}, {20'b0, e.ea});
                        check("autoindexed", {31'b0, autoindexed}, {31'b0, e.ai});
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [11:0] ir_v, input logic [11:0] pc_v, input logic push,
                            input logic err, input logic [11:0] ea_v, input logic ai_v,
                            output int start_cyc);
        exp_t e;
        @(posedge clk);
        #1;
        check("idle_before_start", {31'b0, busy}, 0);
        ir = ir_v;
        pc = pc_v;
        start = 1'b1;
        start_cyc = cyc;
        if (push) begin
            e.err = err; e.ea = ea_v; e.ai = ai_v;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_in_budget", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int sc, rd0, wr0, nr0, nw0;
        reset = 1'b1; start = 1'b0; ir = '0; pc = '0;
        foreach (mem[i]) mem[i] = '0;
        mem[12'o0220] = 12'o3456;
        mem[12'o0010] = 12'o7777;
        mem[12'o0017] = 12'o1234;
        mem[12'o0007] = 12'o0005;
        mem[12'o0020] = 12'o6543;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ea", {20'b0, ea}, 0);
        check("rst_ea_valid", {31'b0, ea_valid}, 0);
        check("rst_mem_error", {31'b0, mem_error}, 0);
        check("rst_enables", {30'b0, mem_read_enable, mem_write_enable}, 0);
        check("rst_mem_address", {20'b0, mem_address}, 0);
        check("rst_mem_write_data", {20'b0, mem_write_data}, 0);
        check("rst_read_type", {31'b0, mem_read_type}, 0);
        reset = 1'b0;
        mem_auto = 1'b1;

        // Direct, current page: no memory traffic at all.
        rd0 = rd_cycles; wr0 = wr_cycles;
        do_start(12'o1220, 12'o4567, 1'b1, 1'b0, 12'o4420, 1'b0, sc);
        drain(20);
        check("direct_latency", last_valid_cyc, sc + 2);
        check("direct_no_enable", (rd_cycles - rd0) + (wr_cycles - wr0), 0);

        // Indirect, current page, outside auto-index window.
        nr0 = n_reads; nw0 = n_writes;
        do_start(12'o1620, 12'o0200, 1'b1, 1'b0, 12'o3456, 1'b0, sc);
        drain(40);
        check("ind_reads", n_reads - nr0, 1);
        check("ind_read_addr", {20'b0, last_rd_addr}, 12'o0220);
        check("ind_writes", n_writes - nw0, 0);
        check("ind_latency", last_valid_cyc, last_fin_cyc + 2);

        // Auto-index at the low edge with wrap 7777 -> 0000.
        nr0 = n_reads; nw0 = n_writes;
        do_start(12'o1410, 12'o0000, 1'b1, 1'b0, 12'o0000, 1'b1, sc);
        drain(40);
        check("ai_reads", n_reads - nr0, 1);
        check("ai_writes", n_writes - nw0, 1);
        check("ai_wr_addr", {20'b0, last_wr_addr}, 12'o0010);
        check("ai_wr_data", {20'b0, last_wr_data}, 12'o0000);
        check("ai_latency", last_valid_cyc, last_fin_cyc + 2);

        // Window edges: 0017 is auto-indexed, 0007 and 0020 are not; a direct clears autoindexed.
        nw0 = n_writes;
        do_start(12'o1417, 12'o0000, 1'b1, 1'b0, 12'o1235, 1'b1, sc);
        drain(40);
        check("ai_hi_wr_data", {20'b0, last_wr_data}, 12'o1235);
        do_start(12'o0055, 12'o0000, 1'b1, 1'b0, 12'o0055, 1'b0, sc);
        drain(20);
        do_start(12'o1407, 12'o0000, 1'b1, 1'b0, 12'o0005, 1'b0, sc);
        drain(40);
        do_start(12'o1420, 12'o0000, 1'b1, 1'b0, 12'o6543, 1'b0, sc);
        drain(40);
        check("edge_writes", n_writes - nw0, 1);

        // No completion: timeout after 16 enabled cycles.
        mem_auto = 1'b0;
        rd0 = rd_cycles;
        do_start(12'o1620, 12'o0200, 1'b1, 1'b1, 12'o0000, 1'b0, sc);
        drain(60);
        check("to_enable_cycles", rd_cycles - rd0, 16);
        check("to_mem_error", {31'b0, mem_error}, 1);
        check("to_busy", {31'b0, busy}, 0);
        check("to_enables", {30'b0, mem_read_enable, mem_write_enable}, 0);

        // Reset during RD, then a stale completion.
        do_start(12'o1620, 12'o0200, 1'b0, 1'b0, 12'o0000, 1'b0, sc);
        repeat (2) @(posedge clk);
        #1;
        check("rd_in_flight", {31'b0, mem_read_enable}, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_mid_enables", {30'b0, mem_read_enable, mem_write_enable}, 0);
        stale_req++;
        repeat (6) @(posedge clk);
        #1;
        check("stale_busy", {31'b0, busy}, 0);
        check("stale_ea", {20'b0, ea}, 0);
        check("stale_autoindexed", {31'b0, autoindexed}, 0);
        check("stale_enables", {30'b0, mem_read_enable, mem_write_enable}, 0);
        check("stale_mem_address", {20'b0, mem_address}, 0);

        // Second start while busy is dropped.
        mem_auto = 1'b1;
        nr0 = n_reads;
        do_start(12'o1620, 12'o0200, 1'b1, 1'b0, 12'o3456, 1'b0, sc);
        check("busy_on_restart", {31'b0, busy}, 1);
        ir = 12'o0020; pc = '0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(40);
        repeat (6) @(posedge clk);
        #1;
        check("restart_ea_held", {20'b0, ea}, 12'o3456);
        check("restart_reads", n_reads - nr0, 1);
`ifdef EAU_STATS_EN
        check("stat_indirect", {16'b0, indirect_count}, 1);
        check("stat_autoindex", {16'b0, autoindex_count}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
